// File: rtl/phys_reg_freelist_ctrl_if.sv
// Rename-stage free-list bus: allocation grant, commit free, branch checkpoint/recover, status.
interface phys_reg_freelist_ctrl_if #(
  parameter int unsigned PREG_W = 6,
  parameter int unsigned CKPT_W = 2,
  parameter int unsigned CNT_W  = 6
);
  logic              alloc_req;
  logic              alloc_gnt;
  logic [PREG_W-1:0] alloc_preg;
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
  logic              ckpt_save;
  logic [CKPT_W-1:0] ckpt_save_id;
  logic              recover;
  logic [CKPT_W-1:0] recover_id;
  logic              ready;
  logic [CNT_W-1:0]  free_count;
  logic              empty;
  logic              err_overflow;

  // Rename / commit / branch-stack side.
  modport master (
    output alloc_req, free_valid, free_preg, ckpt_save, ckpt_save_id, recover, recover_id,
    input  alloc_gnt, alloc_preg, ready, free_count, empty, err_overflow
  );

  // Free-list controller side.
  modport slave (
    input  alloc_req, free_valid, free_preg, ckpt_save, ckpt_save_id, recover, recover_id,
    output alloc_gnt, alloc_preg, ready, free_count, empty, err_overflow
  );
endinterface

// File: rtl/phys_reg_freelist_ctrl.sv
// Physical-register free list: circular FIFO of unmapped pregs, filled with
// NUM_ARCH_REGS..NUM_PHYS_REGS-1 after reset, one grant and one free per cycle, and per-branch
// snapshots of the allocation (head) pointer for single-cycle mispredict recovery.
module phys_reg_freelist_ctrl #(
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned NUM_PHYS_REGS = 64,
  parameter int unsigned NUM_CKPT      = 4,
  parameter int unsigned PREG_W        = 6
) (
  input logic                     clk,
  input logic                     rst_n,
  phys_reg_freelist_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Extra wrap bit distinguishes full from empty.
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [IDX_W-1:0]  init_idx_q, init_idx_d;
  logic              err_q, err_d;
  logic [PREG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  ckpt_q [NUM_CKPT];

  logic [PTR_W-1:0]  count;
  logic              is_empty;
  logic              is_full;
  logic              grant;
  logic              mem_we;
  logic [PREG_W-1:0] mem_wdata;
  logic              ckpt_we;

  // Occupancy derived from registered pointers only.
  always_comb begin
    count    = tail_q - head_q;
    is_empty = (count == '0);
    is_full  = (count == PTR_W'(DEPTH));
  end

  // Next-state: INIT fills the list, RUN services grant/free/checkpoint/recover.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    init_idx_d = init_idx_q;
    err_d      = err_q;
    grant      = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    ckpt_we    = 1'b0;
    unique case (state_q)
      StInit: begin
        mem_we     = 1'b1;
        mem_wdata  = PREG_W'(NUM_ARCH_REGS) + PREG_W'(init_idx_q);
        tail_d     = tail_q + PTR_W'(1);
        init_idx_d = init_idx_q + IDX_W'(1);
        if (init_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // No free->alloc bypass: emptiness comes from registered pointers.
        grant = bus.alloc_req & ~is_empty & ~bus.recover;
        if (grant) begin
          head_d = head_q + PTR_W'(1);
        end
        // Recovery wins over any same-cycle save; the checkpoint captures post-grant head so
        // the branch renamed this cycle keeps its destination.
        if (bus.recover) begin
          head_d = ckpt_q[bus.recover_id];
        end else begin
          ckpt_we = bus.ckpt_save;
        end
        if (bus.free_valid) begin
          mem_we    = 1'b1;
          mem_wdata = bus.free_preg;
          tail_d    = tail_q + PTR_W'(1);
          if (is_full) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Control state and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      head_q     <= '0;
      tail_q     <= '0;
      init_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      init_idx_q <= init_idx_d;
      err_q      <= err_d;
    end
  end

  // Checkpoint slots hold a snapshot of the head pointer (with wrap bit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CKPT; i++) begin
        ckpt_q[i] <= '0;
      end
    end else if (ckpt_we) begin
      ckpt_q[bus.ckpt_save_id] <= head_d;
    end
  end

  // Entry storage; contents are don't-care until written by INIT, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[tail_q[IDX_W-1:0]] <= mem_wdata;
    end
  end

  assign bus.alloc_gnt    = grant;
  assign bus.alloc_preg   = grant ? mem_q[head_q[IDX_W-1:0]] : '0;
  assign bus.ready        = (state_q == StRun);
  assign bus.free_count   = count;
  assign bus.empty        = is_empty;
  assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_phys_reg_freelist_ctrl.sv
// Bench for phys_reg_freelist_ctrl: directed scenarios then randomized traffic, all checked
// against a queue-based model of the free list with an allocation log for branch recovery.
module tb_phys_reg_freelist_ctrl;
  localparam int unsigned NA    = 32;
  localparam int unsigned NP    = 64;
  localparam int unsigned NC    = 4;
  localparam int unsigned PW    = 6;
  localparam int unsigned DEPTH = NP - NA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phys_reg_freelist_ctrl_if #(.PREG_W(PW), .CKPT_W(2), .CNT_W(6)) bus ();

  phys_reg_freelist_ctrl #(
    .NUM_ARCH_REGS(NA),
    .NUM_PHYS_REGS(NP),
    .NUM_CKPT     (NC),
    .PREG_W       (PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: free list as a FIFO, granted pregs appended to a log; a checkpoint is the log
  // length, recovery moves the log suffix back to the front of the list.
  int unsigned m_free[$];
  int unsigned m_log[$];
  int unsigned m_mapped[$];
  bit          m_ready;
  int unsigned m_init_cnt;
  int unsigned m_commit;
  bit          ck_valid[NC];
  int unsigned ck_val[NC];

  bit          last_gnt;
  int unsigned last_preg;
  int unsigned last_count;

  task automatic model_reset();
    m_free.delete();
    m_log.delete();
    m_mapped.delete();
    for (int unsigned i = 0; i < NA; i++) m_mapped.push_back(i);
    m_ready    = 1'b0;
    m_init_cnt = 0;
    m_commit   = 0;
    for (int i = 0; i < NC; i++) begin
      ck_valid[i] = 1'b0;
      ck_val[i]   = 0;
    end
  endtask

  task automatic idle_inputs();
    bus.alloc_req    = 1'b0;
    bus.free_valid   = 1'b0;
    bus.free_preg    = '0;
    bus.ckpt_save    = 1'b0;
    bus.ckpt_save_id = '0;
    bus.recover      = 1'b0;
    bus.recover_id   = '0;
  endtask

  // One clock: compare at negedge, advance model, step past posedge.
  task automatic cycle();
    bit          exp_gnt;
    int unsigned exp_preg;
    int unsigned limit;
    @(negedge clk);
    exp_gnt  = m_ready && bus.alloc_req && (m_free.size() != 0) && !bus.recover;
    exp_preg = exp_gnt ? m_free[0] : 0;
    check_eq("ready", bus.ready, m_ready);
    check_eq("alloc_gnt", bus.alloc_gnt, exp_gnt);
    check_eq("alloc_preg", bus.alloc_preg, exp_preg);
    if (m_ready) begin
      check_eq("free_count", bus.free_count, m_free.size());
      check_eq("empty", bus.empty, m_free.size() == 0);
    end else begin
      check_eq("init_count", bus.free_count, m_init_cnt);
    end
    check_eq("err_overflow", bus.err_overflow, 0);
    last_gnt   = bus.alloc_gnt;
    last_preg  = bus.alloc_preg;
    last_count = bus.free_count;
    if (!m_ready) begin
      m_init_cnt++;
      if (m_init_cnt == DEPTH) begin
        m_ready = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) m_free.push_back(NA + i);
      end
    end else begin
      if (exp_gnt) m_log.push_back(m_free.pop_front());
      if (bus.recover) begin
        int unsigned k;
        k = ck_val[bus.recover_id];
        for (int i = m_log.size() - 1; i >= int'(k); i--) m_free.push_front(m_log[i]);
        while (m_log.size() > k) void'(m_log.pop_back());
        for (int c = 0; c < NC; c++) if (ck_valid[c] && ck_val[c] > k) ck_valid[c] = 1'b0;
      end else if (bus.ckpt_save) begin
        ck_valid[bus.ckpt_save_id] = 1'b1;
        ck_val[bus.ckpt_save_id]   = m_log.size();
      end
      if (bus.free_valid) m_free.push_back(bus.free_preg);
      // Allocations older than every live checkpoint become architecturally mapped.
      limit = m_log.size();
      for (int c = 0; c < NC; c++) if (ck_valid[c] && ck_val[c] < limit) limit = ck_val[c];
      while (m_commit < limit) begin
        m_mapped.push_back(m_log[m_commit]);
        m_commit++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop immediately.
  task automatic do_reset();
    #3;
    rst_n         = 1'b0;
    bus.alloc_req = 1'b1;
    #1;
    check_eq("rst_gnt", bus.alloc_gnt, 0);
    check_eq("rst_preg", bus.alloc_preg, 0);
    check_eq("rst_ready", bus.ready, 0);
    check_eq("rst_count", bus.free_count, 0);
    check_eq("rst_empty", bus.empty, 1);
    check_eq("rst_err", bus.err_overflow, 0);
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned c0;
    int          n;
    bit          found;
    idle_inputs();
    model_reset();
    do_reset();

    // INIT ignores requests.
    bus.alloc_req = 1'b1;
    repeat (DEPTH) cycle();

    // Drain in order, then one refused request.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cycle();
      check_eq("seq_alloc", last_preg, NA + i);
    end
    cycle();
    check_eq("alloc_when_empty", last_gnt, 0);

    // FIFO return order across the index wrap.
    bus.alloc_req  = 1'b0;
    bus.free_valid = 1'b1;
    bus.free_preg  = 6'd40; cycle();
    bus.free_preg  = 6'd7;  cycle();
    bus.free_preg  = 6'd51; cycle();
    bus.free_valid = 1'b0;
    bus.alloc_req  = 1'b1;
    cycle(); check_eq("fifo0", last_preg, 40);
    cycle(); check_eq("fifo1", last_preg, 7);
    cycle(); check_eq("fifo2", last_preg, 51);

    // Reset mid-stream, INIT reruns.
    do_reset();
    repeat (DEPTH) cycle();

    // Checkpoint with the third grant, five more grants, recover.
    bus.alloc_req = 1'b1;
    cycle(); cycle();
    bus.ckpt_save = 1'b1; bus.ckpt_save_id = 2'd1;
    cycle();
    check_eq("ckpt_preg", last_preg, 34);
    bus.ckpt_save = 1'b0;
    repeat (5) cycle();
    bus.recover = 1'b1; bus.recover_id = 2'd1;
    cycle();
    check_eq("recover_nogrant", last_gnt, 0);
    check_eq("pre_recover_count", last_count, 24);
    bus.recover = 1'b0;
    cycle();
    check_eq("post_recover_count", last_count, 29);
    check_eq("post_recover_preg", last_preg, 35);

    // Recover alongside a free: the freed preg lands behind the restored entries.
    bus.ckpt_save = 1'b1; bus.ckpt_save_id = 2'd2;
    cycle();
    bus.ckpt_save = 1'b0;
    cycle(); cycle();
    bus.recover = 1'b1; bus.recover_id = 2'd2;
    bus.free_valid = 1'b1; bus.free_preg = 6'd9;
    cycle();
    c0 = last_count;
    bus.recover = 1'b0; bus.free_valid = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 64) begin
      cycle();
      n++;
      if (last_gnt && last_preg == 9) found = 1'b1;
    end
    check_eq("free9_found", found, 1);
    check_eq("free9_pos", n, c0 + 3);

    // Empty list: same-cycle free does not feed a grant.
    bus.free_valid = 1'b1; bus.free_preg = 6'd12;
    cycle();
    check_eq("no_bypass", last_gnt, 0);
    bus.free_valid = 1'b0;
    cycle();
    check_eq("bypass_next", last_preg, 12);

    // Randomized traffic obeying register conservation.
    do_reset();
    repeat (DEPTH) cycle();
    for (int t = 0; t < 3000; t++) begin
      idle_inputs();
      bus.alloc_req = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) ck_valid[$urandom_range(0, NC - 1)] = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        for (int tries = 0; tries < 8; tries++) begin
          int unsigned s;
          s = $urandom_range(0, NC - 1);
          if (ck_valid[s]) begin
            bus.recover    = 1'b1;
            bus.recover_id = s[1:0];
            break;
          end
        end
      end
      if ($urandom_range(0, 5) == 0) begin
        bus.ckpt_save    = 1'b1;
        bus.ckpt_save_id = 2'($urandom_range(0, NC - 1));
      end
      if (m_mapped.size() > NA && $urandom_range(0, 1) == 1) begin
        int unsigned idx;
        idx            = $urandom_range(0, m_mapped.size() - 1);
        bus.free_valid = 1'b1;
        bus.free_preg  = 6'(m_mapped[idx]);
        m_mapped.delete(idx);
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
